// File: rtl/router_pkg.sv
// router_pkg: shared widths, SRAM select codes and loader FSM states for the router slice.
package router_pkg;
   localparam int SRAM_DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 8;
   localparam int SEL_WIDTH = 2;
   typedef enum logic [SEL_WIDTH-1:0] {SEL_WEIGHT = 0, SEL_INPUT = 1} sram_sel_e;
   typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_e;
endpackage

// File: rtl/sram_stream_loader.sv
// sram_stream_loader: writes a valid/ready word stream into the selected SRAM at
// auto-incrementing addresses, then reports the last address and optionally enables routing.
module sram_stream_loader
   import router_pkg::*;
(
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [SEL_WIDTH-1:0]       i_sram_select,
   input  logic [ADDR_WIDTH-1:0]      i_base_addr,
   input  logic [ADDR_WIDTH:0]        i_count,
   input  logic                       i_auto_route,
   input  logic                       i_route_stop,
   input  logic                       i_s_valid,
   input  logic [SRAM_DATA_WIDTH-1:0] i_s_data,
   input  logic                       i_s_last,
   output logic                       o_s_ready,
   output logic                       o_write_en,
   output logic [ADDR_WIDTH-1:0]      o_write_addr,
   output logic [SRAM_DATA_WIDTH-1:0] o_data_out,
   output logic [SEL_WIDTH-1:0]       o_sram_select,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err_short,
   output logic [ADDR_WIDTH-1:0]      o_last_addr,
   output logic                       o_route_en
);
   loader_state_e state_q, state_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d, osel_q, osel_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d, last_q, last_d, wa;
   logic [ADDR_WIDTH:0] cnt_q, cnt_d, idx_q, idx_d;
   logic [SRAM_DATA_WIDTH-1:0] data_q, data_d;
   logic auto_q, auto_d, we_q, we_d, done_q, done_d, err_q, err_d, route_q, route_d;
   logic start, xfer, hit_cnt, fin;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         osel_q  <= '0;
         base_q  <= '0;
         addr_q  <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         auto_q  <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         route_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         osel_q  <= osel_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         auto_q  <= auto_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
         route_q <= route_d;
      end
   end

   always_comb begin
      start   = i_start && state_q != LOAD;
      xfer    = state_q == LOAD && i_s_valid;
      hit_cnt = idx_q + 1'b1 == cnt_q;
      fin     = xfer && (hit_cnt || i_s_last);
      wa      = base_q + idx_q[ADDR_WIDTH-1:0];
      state_d = state_q;
      sel_d   = sel_q;
      osel_d  = osel_q;
      base_d  = base_q;
      addr_d  = addr_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      auto_d  = auto_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      if (start) begin
         sel_d   = i_sram_select;
         base_d  = i_base_addr;
         cnt_d   = i_count;
         idx_d   = '0;
         auto_d  = i_auto_route;
         err_d   = 1'b0;
         state_d = i_count == '0 ? DONE : LOAD;
         done_d  = i_count == '0;
         last_d  = i_count == '0 ? i_base_addr - 1'b1 : last_q;
      end
      if (xfer) begin
         we_d   = 1'b1;
         addr_d = wa;
         data_d = i_s_data;
         osel_d = sel_q;
         idx_d  = idx_q + 1'b1;
      end
      // Completion is registered alongside the final write so done and strobe coincide.
      if (fin) begin
         state_d = DONE;
         done_d  = 1'b1;
         last_d  = wa;
         err_d   = i_s_last && !hit_cnt;
      end
      route_d = (start || i_route_stop) ? 1'b0 : (done_q && auto_q) ? 1'b1 : route_q;
   end

   assign o_s_ready     = state_q == LOAD;
   assign o_busy        = state_q == LOAD;
   assign o_write_en    = we_q;
   assign o_write_addr  = addr_q;
   assign o_data_out    = data_q;
   assign o_sram_select = osel_q;
   assign o_done        = done_q;
   assign o_err_short   = err_q;
   assign o_last_addr   = last_q;
   assign o_route_en    = route_q;
endmodule

// File: tb/tb_sram_stream_loader.sv
// tb_sram_stream_loader: table-driven load cases with a write scoreboard, plus reset and
// start-during-load sequences.
module tb_sram_stream_loader;
   logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_auto_route = 1'b0, i_route_stop = 1'b0;
   logic [1:0] i_sram_select = '0;
   logic [7:0] i_base_addr = '0;
   logic [8:0] i_count = '0;
   logic i_s_valid = 1'b0, i_s_last = 1'b0;
   logic [63:0] i_s_data = '0;
   logic o_s_ready, o_write_en, o_busy, o_done, o_err_short, o_route_en;
   logic [7:0] o_write_addr, o_last_addr;
   logic [63:0] o_data_out;
   logic [1:0] o_sram_select;

   sram_stream_loader dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_sram_select(i_sram_select),
      .i_base_addr(i_base_addr), .i_count(i_count), .i_auto_route(i_auto_route),
      .i_route_stop(i_route_stop), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
      .i_s_last(i_s_last), .o_s_ready(o_s_ready), .o_write_en(o_write_en),
      .o_write_addr(o_write_addr), .o_data_out(o_data_out), .o_sram_select(o_sram_select),
      .o_busy(o_busy), .o_done(o_done), .o_err_short(o_err_short), .o_last_addr(o_last_addr),
      .o_route_en(o_route_en)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [7:0] base;
      logic [8:0] cnt;
      logic [1:0] sel;
      int nw;
      int last_i;
      bit gap;
      bit auto_r;
      int exp_wr;
      logic [7:0] exp_last;
      bit exp_err;
   } vec_t;

   typedef struct packed {
      logic [7:0] a;
      logic [63:0] d;
      logic [1:0] s;
      logic fin;
   } exp_t;

   exp_t q[$];
   vec_t vecs[8];
   int checks = 0, errors = 0, nwr, ndone;
   bit prev_done, exp_auto;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, want);
      end
   endtask

   task automatic mon();
      exp_t e;
      if (prev_done) chk("route_after_done", {63'd0, o_route_en}, {63'd0, exp_auto});
      prev_done = o_done;
      if (o_done) ndone++;
      if (o_write_en) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write got=%h want=none", o_write_addr);
         end else begin
            e = q.pop_front();
            nwr++;
            chk("wr_addr", {56'd0, o_write_addr}, {56'd0, e.a});
            chk("wr_data", o_data_out, e.d);
            chk("wr_sel", {62'd0, o_sram_select}, {62'd0, e.s});
            chk("wr_done", {63'd0, o_done}, {63'd0, e.fin});
         end
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
      mon();
   endtask

   task automatic run_case(input int k, input vec_t v);
      int acc, cyc;
      logic [63:0] dat;
      exp_auto = v.auto_r;
      nwr = 0;
      ndone = 0;
      prev_done = 0;
      i_base_addr = v.base;
      i_count = v.cnt;
      i_sram_select = v.sel;
      i_auto_route = v.auto_r;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("start_err_clr", {63'd0, o_err_short}, 64'd0);
      chk("start_route_clr", {63'd0, o_route_en}, 64'd0);
      if (v.cnt == 0) chk("zero_done", {63'd0, o_done}, 64'd1);
      acc = 0;
      cyc = 0;
      while ((acc < v.exp_wr || q.size() != 0) && cyc < 400) begin
         dat = {32'(k), 32'(acc)};
         i_s_valid = (acc < v.nw) && !(v.gap && cyc[0]);
         i_s_data = dat;
         i_s_last = acc == v.last_i;
         chk("ready", {63'd0, o_s_ready}, {63'd0, acc < v.exp_wr});
         chk("busy", {63'd0, o_busy}, {63'd0, acc < v.exp_wr});
         if (i_s_valid && acc < v.exp_wr) begin
            q.push_back('{a: v.base + 8'(acc), d: dat, s: v.sel, fin: acc + 1 == v.exp_wr});
            acc++;
         end
         tick();
         cyc++;
      end
      if (cyc >= 400) begin
         checks++;
         errors++;
         $display("FAIL timeout_case%0d got=%0d want=%0d", k, acc, v.exp_wr);
         q.delete();
      end
      for (int i = 0; i < 3; i++) begin
         chk("held_ready", {63'd0, o_s_ready}, 64'd0);
         tick();
      end
      chk("write_count", 64'(nwr), 64'(v.exp_wr));
      chk("done_pulses", 64'(ndone), 64'd1);
      chk("last_addr", {56'd0, o_last_addr}, {56'd0, v.exp_last});
      chk("err_short", {63'd0, o_err_short}, {63'd0, v.exp_err});
      chk("route_level", {63'd0, o_route_en}, {63'd0, v.auto_r});
      if (v.auto_r) begin
         i_route_stop = 1'b1;
         tick();
         i_route_stop = 1'b0;
         chk("route_stop", {63'd0, o_route_en}, 64'd0);
      end
      i_s_valid = 1'b0;
      i_s_last = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      vecs[0] = '{8'h00, 9'd9,   2'd0, 9,   8,  0, 0, 9,   8'h08, 0};
      vecs[1] = '{8'hFC, 9'd8,   2'd1, 8,   7,  1, 0, 8,   8'h03, 0};
      vecs[2] = '{8'h00, 9'd9,   2'd0, 9,   3,  0, 0, 4,   8'h03, 1};
      vecs[3] = '{8'h20, 9'd3,   2'd1, 5,   -1, 0, 1, 3,   8'h22, 0};
      vecs[4] = '{8'h40, 9'd0,   2'd0, 0,   -1, 0, 0, 0,   8'h3F, 0};
      vecs[5] = '{8'h80, 9'd256, 2'd2, 256, 255, 0, 0, 256, 8'h7F, 0};
      vecs[6] = '{8'hFF, 9'd1,   2'd1, 1,   0,  0, 0, 1,   8'hFF, 0};
      vecs[7] = '{8'h30, 9'd4,   2'd3, 4,   3,  1, 1, 4,   8'h33, 0};
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_done", {63'd0, o_done}, 64'd0);
      chk("rst_ready", {63'd0, o_s_ready}, 64'd0);
      chk("rst_write_en", {63'd0, o_write_en}, 64'd0);
      chk("rst_last_addr", {56'd0, o_last_addr}, 64'd0);
      i_rst = 1'b0;
      for (int k = 0; k < 8; k++) run_case(k, vecs[k]);
      // Mid-load reset, with an ignored start pulse on the second word.
      exp_auto = 0;
      prev_done = 0;
      nwr = 0;
      i_base_addr = 8'h10;
      i_count = 9'd6;
      i_sram_select = 2'd1;
      i_auto_route = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int n = 0; n < 2; n++) begin
         i_s_valid = 1'b1;
         i_s_data = 64'hA0 + 64'(n);
         i_s_last = 1'b0;
         if (n == 1) begin
            i_start = 1'b1;
            i_base_addr = 8'h99;
            i_count = 9'd2;
         end
         q.push_back('{a: 8'h10 + 8'(n), d: 64'hA0 + 64'(n), s: 2'd1, fin: 1'b0});
         tick();
         i_start = 1'b0;
      end
      chk("mid_write_count", 64'(nwr), 64'd2);
      chk("mid_busy", {63'd0, o_busy}, 64'd1);
      i_s_data = 64'hA2;
      #3;
      i_rst = 1'b1;
      #1;
      chk("arst_write_en", {63'd0, o_write_en}, 64'd0);
      chk("arst_addr", {56'd0, o_write_addr}, 64'd0);
      chk("arst_data", o_data_out, 64'd0);
      chk("arst_sel", {62'd0, o_sram_select}, 64'd0);
      chk("arst_busy", {63'd0, o_busy}, 64'd0);
      chk("arst_ready", {63'd0, o_s_ready}, 64'd0);
      chk("arst_last", {56'd0, o_last_addr}, 64'd0);
      chk("arst_err_route", {62'd0, o_err_short, o_route_en}, 64'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_hold_write", {63'd0, o_write_en}, 64'd0);
      end
      i_rst = 1'b0;
      i_s_valid = 1'b0;
      tick();
      rv = '{8'h10, 9'd3, 2'd0, 3, 2, 0, 0, 3, 8'h12, 0};
      run_case(9, rv);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
